// File: rtl/axilite_reg_arb_pkg.sv
// Shared types and helpers for the register-port arbiter: FSM state encoding,
// the round-robin scan and the read-latency counter width.
package axilite_reg_arb_pkg;

  typedef enum logic [1:0] {IDLE, WR, RD_WAIT, RESP} state_e;

  localparam int MAX_REQ = 8;

  // Counter must hold 0..lat; keep at least one bit so lat=0 still builds.
  function automatic int rd_cnt_w(input int lat);
    return ($clog2(lat + 1) < 1) ? 1 : $clog2(lat + 1);
  endfunction

  // First valid index scanning last+1 .. last+n (mod n).
  function automatic int rr_pick(input logic [MAX_REQ-1:0] valid, input int last, input int n);
    int   pick;
    int   idx;
    logic found;
    pick  = 0;
    found = 1'b0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      if (k <= n) begin
        idx = (last + k) % n;
        if (!found && valid[idx]) begin
          pick  = idx;
          found = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/axilite_reg_port_arbiter_rr.sv
// Purely combinational round-robin picker, reusable by any arbiter that
// tracks its own last grant.
module rr_arbiter_comb
  import axilite_reg_arb_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [IDX_W-1:0] last_grant,
  output logic [IDX_W-1:0] pick,
  output logic             any_valid
);

  logic [MAX_REQ-1:0] valid_x;
  int                 pick_i;

  always_comb begin
    valid_x              = '0;
    valid_x[N_REQ-1:0]   = valid;
    pick_i               = rr_pick(valid_x, int'(last_grant), N_REQ);
  end

  assign pick      = IDX_W'(pick_i);
  assign any_valid = |valid;

endmodule

// File: rtl/axilite_reg_port_arbiter.sv
// Shares one register port between N_REQ requesters, one transaction in
// flight at a time, granted round robin.
module axilite_reg_port_arbiter
  import axilite_reg_arb_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 3,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic                          axis_aclk,
  input  logic                          axis_areset,
  input  logic [N_REQ-1:0]              req_valid,
  output logic [N_REQ-1:0]              req_ready,
  input  logic [N_REQ-1:0]              req_we,
  input  logic [N_REQ-1:0][ADDR_W-1:0]  req_addr,
  input  logic [N_REQ-1:0][DATA_W-1:0]  req_wdata,
  output logic [N_REQ-1:0]              rsp_valid,
  input  logic [N_REQ-1:0]              rsp_ready,
  output logic [DATA_W-1:0]             rsp_rdata,
  output logic [DATA_W-1:0]             reg_wdata,
  output logic [ADDR_W-1:0]             reg_waddr,
  output logic                          reg_wvalid,
  output logic [ADDR_W-1:0]             reg_raddr,
  input  logic [DATA_W-1:0]             reg_rdata,
  output logic                          busy
);

  localparam int IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int RD_CNT_W = rd_cnt_w(RD_LAT);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    last_grant_q, last_grant_d;
  logic [IDX_W-1:0]    grant_q, grant_d;
  logic [RD_CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic                reg_wvalid_q, reg_wvalid_d;
  logic [ADDR_W-1:0]   reg_waddr_q, reg_waddr_d;
  logic [DATA_W-1:0]   reg_wdata_q, reg_wdata_d;
  logic [ADDR_W-1:0]   reg_raddr_q, reg_raddr_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

  logic [IDX_W-1:0]    pick;
  logic                any_valid;
  logic                rd_done;

  rr_arbiter_comb #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_rr (
    .valid      (req_valid),
    .last_grant (last_grant_q),
    .pick       (pick),
    .any_valid  (any_valid)
  );

  assign rd_done = (rd_cnt_q == RD_CNT_W'(RD_LAT));

  always_ff @(posedge axis_aclk) begin
    if (axis_areset) begin
      state_q      <= IDLE;
      last_grant_q <= IDX_W'(N_REQ - 1);
      grant_q      <= '0;
      rd_cnt_q     <= '0;
      reg_wvalid_q <= 1'b0;
      reg_waddr_q  <= '0;
      reg_wdata_q  <= '0;
      reg_raddr_q  <= '0;
      rsp_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      rd_cnt_q     <= rd_cnt_d;
      reg_wvalid_q <= reg_wvalid_d;
      reg_waddr_q  <= reg_waddr_d;
      reg_wdata_q  <= reg_wdata_d;
      reg_raddr_q  <= reg_raddr_d;
      rsp_rdata_q  <= rsp_rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_valid) state_d = req_we[pick] ? WR : RD_WAIT;
      WR:      state_d = RESP;
      RD_WAIT: if (rd_done) state_d = RESP;
      RESP:    if (rsp_ready[grant_q]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Write strobe/address/data are loaded on the handshake so they appear
  // registered in the single WR cycle.
  always_comb begin
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    rd_cnt_d     = rd_cnt_q;
    reg_wvalid_d = 1'b0;
    reg_waddr_d  = reg_waddr_q;
    reg_wdata_d  = reg_wdata_q;
    reg_raddr_d  = reg_raddr_q;
    rsp_rdata_d  = rsp_rdata_q;
    case (state_q)
      IDLE: if (any_valid) begin
        grant_d = pick;
        if (req_we[pick]) begin
          reg_wvalid_d = 1'b1;
          reg_waddr_d  = req_addr[pick];
          reg_wdata_d  = req_wdata[pick];
        end else begin
          reg_raddr_d = req_addr[pick];
          rd_cnt_d    = '0;
        end
      end
      WR:      rsp_rdata_d = '0;
      RD_WAIT: if (rd_done) rsp_rdata_d = reg_rdata;
               else         rd_cnt_d    = rd_cnt_q + RD_CNT_W'(1);
      RESP:    if (rsp_ready[grant_q]) last_grant_d = grant_q;
      default: ;
    endcase
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    if (state_q == IDLE && any_valid && !axis_areset) req_ready[pick] = 1'b1;
    if (state_q == RESP) rsp_valid[grant_q] = 1'b1;
    busy = (state_q != IDLE);
  end

  assign reg_wvalid = reg_wvalid_q;
  assign reg_waddr  = reg_waddr_q;
  assign reg_wdata  = reg_wdata_q;
  assign reg_raddr  = reg_raddr_q;
  assign rsp_rdata  = rsp_rdata_q;

endmodule
